// File: rtl/exc_trap_ctrl.sv
// rtl/exc_trap_ctrl.sv - exception/interrupt sequencer and CP0 SR/Cause/EPC/PRId owner
module exc_trap_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID         = 32'h4D49_5053,
    parameter int          INT_W        = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] HWInt,
    input  logic             ErrorRlE,
    input  logic [31:0]      PCE,
    input  logic             BDE,
    input  logic             EretE,
    input  logic             MulBusyE,
    input  logic             CP0WeE,
    input  logic [4:0]       CP0AddrE,
    input  logic [31:0]      CP0WDataE,
    output logic [31:0]      CP0RData,
    output logic             InterruptRequest,
    output logic             Nullify,
    output logic             StallFD,
    output logic             RedirectValid,
    output logic [31:0]      RedirectPC,
    output logic             EXL
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP, S_RETURN} state_t;

    state_t             state_q, state_d;
    logic [INT_W-1:0]   im_q, im_d;
    logic [INT_W-1:0]   ip_q, ip_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic               bd_q, bd_d;
    logic               irq_q, irq_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;

    logic               int_pend;
    logic               trap_entry;
    logic               trap_irq;
    logic [4:0]         trap_code;
    logic               cp0_wr;

    assign int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q & (PCE != 32'd0);
    assign EXL      = exl_q;

    always_comb begin
        state_d          = state_q;
        trap_entry       = 1'b0;
        trap_irq         = 1'b0;
        trap_code        = 5'd0;
        Nullify          = 1'b0;
        RedirectValid    = 1'b0;
        RedirectPC       = 32'd0;
        InterruptRequest = 1'b0;
        StallFD          = 1'b0;
        case (state_q)
            S_RUN: begin
                if (ErrorRlE) begin
                    state_d    = S_TRAP;
                    trap_entry = 1'b1;
                    trap_code  = 5'd10;
                end else if (int_pend && MulBusyE) begin
                    state_d = S_DRAIN;
                end else if (int_pend) begin
                    state_d    = S_TRAP;
                    trap_entry = 1'b1;
                    trap_irq   = 1'b1;
                end else if (EretE) begin
                    state_d = S_RETURN;
                end
            end
            S_DRAIN: begin
                // Losing the interrupt wins over the multiplier finishing: no reason left to trap.
                StallFD = 1'b1;
                if (!int_pend) begin
                    state_d = S_RUN;
                end else if (!MulBusyE) begin
                    state_d    = S_TRAP;
                    trap_entry = 1'b1;
                    trap_irq   = 1'b1;
                end
            end
            S_TRAP: begin
                Nullify          = 1'b1;
                RedirectValid    = 1'b1;
                RedirectPC       = HANDLER_ADDR;
                InterruptRequest = irq_q;
                state_d          = S_RUN;
            end
            S_RETURN: begin
                Nullify       = 1'b1;
                RedirectValid = 1'b1;
                RedirectPC    = epc_q;
                state_d       = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign cp0_wr = CP0WeE && (state_q == S_RUN) && (state_d == S_RUN);

    always_comb begin
        im_d       = im_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        bd_d       = bd_q;
        irq_d      = irq_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt;
        if (cp0_wr && CP0AddrE == 5'd12) begin
            im_d  = CP0WDataE[10 +: INT_W];
            exl_d = CP0WDataE[1];
            ie_d  = CP0WDataE[0];
        end
        if (cp0_wr && CP0AddrE == 5'd14) begin
            epc_d = CP0WDataE;
        end
        if (trap_entry) begin
            exc_code_d = trap_code;
            irq_d      = trap_irq;
            // A nested exception keeps the outer return point.
            if (!exl_q) begin
                epc_d = BDE ? (PCE - 32'd4) : PCE;
                bd_d  = BDE;
            end
        end
        if (state_q == S_TRAP) begin
            exl_d = 1'b1;
        end else if (state_q == S_RETURN) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            im_q       <= '0;
            ip_q       <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            bd_q       <= 1'b0;
            irq_q      <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            bd_q       <= bd_d;
            irq_q      <= irq_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        CP0RData = 32'd0;
        case (CP0AddrE)
            5'd12: begin
                CP0RData[10 +: INT_W] = im_q;
                CP0RData[1]           = exl_q;
                CP0RData[0]           = ie_q;
            end
            5'd13: begin
                CP0RData[31]          = bd_q;
                CP0RData[10 +: INT_W] = ip_q;
                CP0RData[6:2]         = exc_code_q;
            end
            5'd14:   CP0RData = epc_q;
            5'd15:   CP0RData = PRID;
            default: CP0RData = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_trap_ctrl.sv
// tb/tb_exc_trap_ctrl.sv - scoreboard bench for exc_trap_ctrl redirects and CP0 state
module tb_exc_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  HWInt;
    logic        ErrorRlE, BDE, EretE, MulBusyE, CP0WeE;
    logic [31:0] PCE, CP0WDataE;
    logic [4:0]  CP0AddrE;
    logic [31:0] CP0RData, RedirectPC;
    logic        InterruptRequest, Nullify, StallFD, RedirectValid, EXL;

    typedef struct {
        int          cyc;
        logic        irq;
        logic [31:0] pc;
    } redir_t;

    redir_t sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     stall_cnt = 0;

    exc_trap_ctrl dut (
        .clk(clk), .reset(reset), .HWInt(HWInt), .ErrorRlE(ErrorRlE), .PCE(PCE),
        .BDE(BDE), .EretE(EretE), .MulBusyE(MulBusyE), .CP0WeE(CP0WeE),
        .CP0AddrE(CP0AddrE), .CP0WDataE(CP0WDataE), .CP0RData(CP0RData),
        .InterruptRequest(InterruptRequest), .Nullify(Nullify), .StallFD(StallFD),
        .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .EXL(EXL)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        HWInt = '0; ErrorRlE = 0; BDE = 0; EretE = 0; MulBusyE = 0;
        CP0WeE = 0; PCE = 32'd0; CP0WDataE = 32'd0; CP0AddrE = 5'd0;
    endtask

    task automatic expect_redir(input logic irq, input logic [31:0] pc);
        redir_t e;
        e.cyc = cyc + 1;
        e.irq = irq;
        e.pc  = pc;
        sb_q.push_back(e);
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0AddrE = addr;
        #1;
        check_eq(tag, CP0RData, exp);
    endtask

    // Returns from the handler: eret in E, then a bubble while fetch is redirected.
    task automatic do_eret(input logic [31:0] epc);
        EretE = 1; PCE = 32'h0000_4184;
        expect_redir(1'b0, epc);
        tick();
        EretE = 0; PCE = 32'd0;
        tick();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (StallFD) stall_cnt++;
            if (RedirectValid) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_redirect", 32'(RedirectValid), 32'd0);
                end else begin
                    redir_t e;
                    e = sb_q.pop_front();
                    check_eq("redir_cycle", 32'(cyc), 32'(e.cyc));
                    check_eq("redir_pc", RedirectPC, e.pc);
                    check_eq("redir_irq", 32'(InterruptRequest), 32'(e.irq));
                    check_eq("redir_nullify", 32'(Nullify), 32'd1);
                end
            end
        end
    end

    initial begin
        reset = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_exl", 32'(EXL), 32'd0);
        check_eq("rst_redir", 32'(RedirectValid), 32'd0);
        check_eq("rst_nullify", 32'(Nullify), 32'd0);
        check_eq("rst_stall", 32'(StallFD), 32'd0);
        chk_rd("rst_sr", 5'd12, 32'd0);
        chk_rd("rst_cause", 5'd13, 32'd0);
        chk_rd("rst_epc", 5'd14, 32'd0);
        reset = 1;
        tick();

        // Enable IM[0]/IE, then an interrupt on a valid PC.
        CP0WeE = 1; CP0AddrE = 5'd12; CP0WDataE = 32'h0000_0401;
        tick();
        CP0WeE = 0;
        chk_rd("sr_write", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001; PCE = 32'h0000_3008; BDE = 0;
        expect_redir(1'b1, 32'h0000_4180);
        tick();
        HWInt = '0; PCE = 32'd0;
        tick();
        check_eq("irq_exl", 32'(EXL), 32'd1);
        chk_rd("irq_epc", 5'd14, 32'h0000_3008);
        chk_rd("irq_cause", 5'd13, 32'h0000_0000);
        do_eret(32'h0000_3008);
        check_eq("eret_exl", 32'(EXL), 32'd0);

        // Reserved instruction in a delay slot.
        ErrorRlE = 1; PCE = 32'h0000_3010; BDE = 1;
        expect_redir(1'b0, 32'h0000_4180);
        tick();
        ErrorRlE = 0; PCE = 32'd0; BDE = 0;
        tick();
        chk_rd("ri_epc", 5'd14, 32'h0000_300C);
        chk_rd("ri_cause", 5'd13, 32'h8000_0028);
        do_eret(32'h0000_300C);

        // Interrupt waits for a 5-cycle multiplier drain.
        HWInt = 6'b000001; PCE = 32'h0000_3020; MulBusyE = 1;
        stall_cnt = 0;
        repeat (5) tick();
        MulBusyE = 0;
        expect_redir(1'b1, 32'h0000_4180);
        tick();
        HWInt = '0; PCE = 32'd0;
        tick();
        check_eq("drain_stall_cycles", 32'(stall_cnt), 32'd5);
        chk_rd("drain_epc", 5'd14, 32'h0000_3020);
        do_eret(32'h0000_3020);

        // Interrupt withdrawn mid-drain: no trap.
        HWInt = 6'b000001; PCE = 32'h0000_3040; MulBusyE = 1;
        repeat (3) tick();
        check_eq("abort_stall", 32'(StallFD), 32'd1);
        HWInt = '0;
        tick();
        check_eq("abort_run", 32'(StallFD), 32'd0);
        MulBusyE = 0;
        repeat (2) tick();
        chk_rd("abort_epc", 5'd14, 32'h0000_3020);
        check_eq("abort_exl", 32'(EXL), 32'd0);

        // Error and interrupt together; interrupt taken after eret.
        HWInt = 6'b000001; ErrorRlE = 1; PCE = 32'h0000_3050;
        expect_redir(1'b0, 32'h0000_4180);
        tick();
        ErrorRlE = 0; PCE = 32'd0;
        tick();
        check_eq("both_exl", 32'(EXL), 32'd1);
        chk_rd("both_cause", 5'd13, 32'h0000_0428);
        do_eret(32'h0000_3050);
        check_eq("both_eret_exl", 32'(EXL), 32'd0);
        PCE = 32'h0000_3050;
        expect_redir(1'b1, 32'h0000_4180);
        tick();
        HWInt = '0; PCE = 32'd0;
        tick();
        chk_rd("late_irq_epc", 5'd14, 32'h0000_3050);
        do_eret(32'h0000_3050);

        // Asynchronous reset while draining.
        HWInt = 6'b000001; PCE = 32'h0000_3060; MulBusyE = 1;
        repeat (2) tick();
        check_eq("pre_rst_stall", 32'(StallFD), 32'd1);
        reset = 0;
        #1;
        check_eq("mid_rst_stall", 32'(StallFD), 32'd0);
        check_eq("mid_rst_redir", 32'(RedirectValid), 32'd0);
        check_eq("mid_rst_exl", 32'(EXL), 32'd0);
        chk_rd("mid_rst_epc", 5'd14, 32'd0);
        idle();
        tick();
        reset = 1;
        tick();
        chk_rd("post_rst_sr", 5'd12, 32'd0);

        // Read-only / ignored CP0 writes and EPC write.
        chk_rd("prid", 5'd15, 32'h4D49_5053);
        CP0WeE = 1; CP0AddrE = 5'd13; CP0WDataE = 32'hFFFF_FFFF;
        tick();
        CP0AddrE = 5'd15;
        tick();
        CP0AddrE = 5'd14; CP0WDataE = 32'h0000_1234;
        tick();
        CP0WeE = 0;
        chk_rd("cause_ro", 5'd13, 32'd0);
        chk_rd("prid_ro", 5'd15, 32'h4D49_5053);
        chk_rd("epc_write", 5'd14, 32'h0000_1234);
        chk_rd("unmapped", 5'd3, 32'd0);
        repeat (2) tick();

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exc_trap_ctrl.md
Name: exc_trap_ctrl

Overview:
- Exception/interrupt sequencer for the 5-stage MIPS pipeline, sitting beside the D->E exception carrier register.
- Decides when the instruction in E traps, drives Nullify/InterruptRequest into the carrier, and drains a busy multiplier before an interrupt is taken.
- Redirects fetch to the handler or to EPC, and owns the CP0 registers SR(12), Cause(13), EPC(14) and PRId(15).

Parameters:
- HANDLER_ADDR, 32'h0000_4180, fetch redirect target on any trap.
- PRID, 32'h4D49_5053, read-only value returned for CP0 register 15.
- INT_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- HWInt  in  INT_W  level-sensitive hardware interrupt lines.
- ErrorRlE  in  1  reserved-instruction error flag of the instruction in E.
- PCE  in  32  PC of the instruction in E; 0 = bubble.
- BDE  in  1  instruction in E is in a branch delay slot.
- EretE  in  1  instruction in E is eret.
- MulBusyE  in  1  multi-cycle multiplier is busy.
- CP0WeE  in  1  mtc0 in E.
- CP0AddrE  in  5  CP0 register number.
- CP0WDataE  in  32  mtc0 data.
- CP0RData  out  32  mfc0 data; combinational from CP0AddrE.
- InterruptRequest  out  1  interrupt trap in progress.
- Nullify  out  1  kill the D->E and E->M stage contents.
- StallFD  out  1  freeze the F and D stages.
- RedirectValid  out  1  load RedirectPC into the PC this cycle.
- RedirectPC  out  32  redirect target.
- EXL  out  1  SR.EXL.

Behaviour:
- Reset (reset=0, async): state=RUN; SR.IM=0, SR.IE=0, EXL=0; Cause=0; EPC=0; all strobes 0.
- Interrupt pending: int_pend = |(HWInt & SR.IM) & SR.IE & ~EXL & (PCE!=0).
- Cause.IP[INT_W-1:0] is sampled from HWInt every cycle.
- States: RUN, DRAIN, TRAP, RETURN.
- RUN, priority order:
  - ErrorRlE -> TRAP, type=exception, ExcCode=10.
  - int_pend & MulBusyE -> DRAIN.
  - int_pend -> TRAP, type=interrupt, ExcCode=0.
  - EretE -> RETURN.
  - Otherwise stay in RUN.
- On the RUN->TRAP or DRAIN->TRAP edge:
  - Latch EPC = BDE ? PCE-4 : PCE, and Cause.BD = BDE.
  - If EXL is already 1 (nested exception), EPC and BD are unchanged; ExcCode is still written.
  - All arithmetic is 32-bit modulo.
- DRAIN:
  - StallFD=1; PCE is held stable by the stall.
  - MulBusyE=0 -> TRAP (interrupt).
  - int_pend drops -> RUN with no trap.
  - ErrorRlE cannot appear, since the E instruction is frozen.
- TRAP (exactly 1 cycle):
  - Nullify=1, RedirectValid=1, RedirectPC=HANDLER_ADDR, InterruptRequest=(type==interrupt).
  - EXL<=1 at end of cycle; next state RUN.
  - Trap-to-handler latency: 1 cycle after detection in E.
- RETURN (1 cycle):
  - Nullify=1, RedirectValid=1, RedirectPC=EPC.
  - EXL<=0 at end of cycle; next state RUN.
- Simultaneous events:
  - ErrorRlE beats interrupt; the interrupt stays pending and is taken after eret.
  - eret executes with EXL=1, so no interrupt can compete with it.
- mtc0:
  - Write takes effect at the clock edge only when state=RUN and no trap/DRAIN/RETURN transition is taken that cycle.
  - Addr 12 writes IM[15:10], EXL[1], IE[0]; other SR bits read 0.
  - Addr 14 writes EPC.
  - Addr 13 and 15 writes are ignored.
  - An mtc0 to EXL that collides with trap entry loses; trap entry sets EXL=1.
- mfc0 read layout:
  - 12: {16'b0, IM, 8'b0, EXL, IE}.
  - 13: {BD, 15'b0, IP, 3'b0, ExcCode, 2'b0}.
  - 14: EPC.
  - 15: PRID.
  - Any other address reads 0.
- Reset mid-operation (DRAIN/TRAP/RETURN) aborts immediately to RUN with reset values; no redirect is issued.

Test Plan:
- Reset, then mtc0 SR=32'h0000_0401, HWInt[0]=1, PCE=32'h0000_3008, BDE=0 -> next cycle TRAP: Nullify=1, InterruptRequest=1, RedirectPC=32'h0000_4180; then EPC=32'h0000_3008, EXL=1, Cause.ExcCode=0.
- ErrorRlE=1 with PCE=32'h0000_3010, BDE=1 -> TRAP with InterruptRequest=0; EPC=32'h0000_300C, Cause.BD=1, ExcCode=10.
- Interrupt pending with MulBusyE high for 5 cycles -> StallFD=1 for 5 cycles; TRAP fires in the cycle after MulBusyE falls; EPC = the frozen PCE. Repeat, dropping HWInt mid-DRAIN -> return to RUN with no redirect.
- ErrorRlE and an enabled interrupt in the same cycle -> ExcCode=10, InterruptRequest=0; EretE next -> RETURN with RedirectPC=EPC, EXL=0; the interrupt trap follows on the next valid PCE.
- Pull reset low while in DRAIN -> state RUN immediately; EXL=0, EPC=0; no RedirectValid pulse.
- mfc0 of addr 15 -> 32'h4D49_5053; mtc0 13 then mfc0 13 -> Cause unchanged.
